// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampled) feeding a first-word-fall-through byte FIFO with sticky errors.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity_err output.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_TICK = 27,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     rx,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                     parity_err,
`endif
    output logic                     overrun
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned DIV_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int unsigned SC_W  = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [DIV_W-1:0]  div_q;
    logic              tick, div_clr;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              brk_q, brk_d;
    logic              push, ferr_evt, perr_evt;
    logic              sc_half, sc_last;

    logic [7:0]        mem_q [DEPTH];
    logic [AW:0]       wptr_q, rptr_q;
    logic              pop, wr_ok, ovr_evt;
    logic              frame_err_q, overrun_q, parity_err_q;

    always_ff @(posedge clk) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick = (div_q == DIV_W'(CLKS_PER_TICK - 1));

    always_ff @(posedge clk) begin
        if (Rst || div_clr || tick) div_q <= '0;
        else                        div_q <= div_q + DIV_W'(1);
    end

    assign sc_half = (sc_q == SC_W'(OVERSAMPLE / 2 - 1));
    assign sc_last = (sc_q == SC_W'(OVERSAMPLE - 1));

    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        brk_d    = brk_q;
        div_clr  = 1'b0;
        push     = 1'b0;
        ferr_evt = 1'b0;
        perr_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    sc_d    = '0;
                    div_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (sc_half) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            sc_d    = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sc_last) begin
                        shift_d[bit_q] = rx_s_q;
                        sc_d           = '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (sc_last) begin
                        perr_evt = ^{shift_q, rx_s_q};
                        sc_d     = '0;
                        state_d  = STOP;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                // After a bad stop bit, hold here until the line returns high so a break reports once.
                if (brk_q) begin
                    if (rx_s_q) begin
                        brk_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (tick) begin
                    if (sc_last) begin
                        if (rx_s_q) begin
                            push    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_evt = 1'b1;
                            brk_d    = 1'b1;
                        end
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= IDLE;
            sc_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            brk_q   <= brk_d;
        end
    end

    assign count   = wptr_q - rptr_q;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign valid   = (count != '0);
    assign dout    = mem_q[rptr_q[AW-1:0]];
    assign pop     = rd_en && valid;
    assign wr_ok   = push && (!full || pop);
    assign ovr_evt = push && full && !pop;

    always_ff @(posedge clk) begin
        if (Rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '{default: '0};
        end else begin
            if (wr_ok) begin
                mem_q[wptr_q[AW-1:0]] <= shift_q;
                wptr_q                <= wptr_q + (AW + 1)'(1);
            end
            if (pop) rptr_q <= rptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= ferr_evt || (frame_err_q && !clr_err);
            overrun_q    <= ovr_evt || (overrun_q && !clr_err);
            parity_err_q <= perr_evt || (parity_err_q && !clr_err);
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_err_q;
`endif

endmodule
